// File: rtl/core_defs.sv
// Shared definitions for the 8-bit RISC core: widths, opcodes, ALU function
// codes and the control sequencer state encoding.
package core_defs;

  localparam int CORE_RFW = 2;
  localparam int CORE_AW  = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_FETCH_IMM = 3'd3,
    ST_LOAD_IMM  = 3'd4,
    ST_EXEC      = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: opcode byte to ALU function and the
// control attributes the sequencer needs in DECODE and EXEC.
module instr_decoder
  import core_defs::*;
(
  input  logic [7:0] ir_i,
  output alu_op_e    alu_op_o,
  output logic       writes_rf_o,
  output logic       wdata_sel_o,
  output logic       is_two_byte_o,
  output logic       sets_flag_o,
  output logic       is_halt_o,
  output logic       is_jmp_o,
  output logic       is_jz_o
);

  always_comb begin
    alu_op_o      = ALU_ADD;
    writes_rf_o   = 1'b0;
    wdata_sel_o   = 1'b0;
    is_two_byte_o = 1'b0;
    sets_flag_o   = 1'b0;
    is_halt_o     = 1'b0;
    is_jmp_o      = 1'b0;
    is_jz_o       = 1'b0;
    case (ir_i[7:4])
      OP_ADD: begin alu_op_o = ALU_ADD; writes_rf_o = 1'b1; sets_flag_o = 1'b1; end
      OP_SUB: begin alu_op_o = ALU_SUB; writes_rf_o = 1'b1; sets_flag_o = 1'b1; end
      OP_AND: begin alu_op_o = ALU_AND; writes_rf_o = 1'b1; sets_flag_o = 1'b1; end
      OP_OR:  begin alu_op_o = ALU_OR;  writes_rf_o = 1'b1; sets_flag_o = 1'b1; end
      OP_XOR: begin alu_op_o = ALU_XOR; writes_rf_o = 1'b1; sets_flag_o = 1'b1; end
      OP_MOV: begin alu_op_o = ALU_PASS_B; writes_rf_o = 1'b1; end
      OP_LDI: begin writes_rf_o = 1'b1; wdata_sel_o = 1'b1; is_two_byte_o = 1'b1; end
      OP_JMP: begin is_two_byte_o = 1'b1; is_jmp_o = 1'b1; end
      OP_JZ:  begin is_two_byte_o = 1'b1; is_jz_o = 1'b1; end
      OP_HALT: is_halt_o = 1'b1;
      // NOP and the unassigned opcodes A-E fall through with no side effects
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns PC, IR, the immediate
// latch and the zero flag, and drives the register file / ALU controls.
module control_sequencer
  import core_defs::*;
#(
  parameter int RFW = CORE_RFW,
  parameter int AW  = CORE_AW
) (
  input  logic           clk,
  input  logic           cu_reset_n,
  output logic [AW-1:0]  instr_addr,
  input  logic [7:0]     instr_data,
  input  logic           alu_zero,
  output logic           rf_reset,
  output logic           rf_we,
  output logic [RFW-1:0] reg1,
  output logic [RFW-1:0] reg2,
  output logic [RFW-1:0] wreg,
  output logic [2:0]     alu_op,
  output logic           wdata_sel,
  output logic [7:0]     imm,
  output logic           halted,
  output state_e         dbg_state
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic [7:0]    imm_q, imm_d;
  logic          zflag_q, zflag_d;

  logic [7:0] dec_ir;
  alu_op_e    dec_alu_op;
  logic       dec_writes_rf, dec_wdata_sel, dec_two_byte, dec_sets_flag;
  logic       dec_halt, dec_jmp, dec_jz;

  // In DECODE the byte is still on the memory bus; elsewhere decode the IR.
  assign dec_ir = (state_q == ST_DECODE) ? instr_data : ir_q;

  instr_decoder u_dec (
    .ir_i          (dec_ir),
    .alu_op_o      (dec_alu_op),
    .writes_rf_o   (dec_writes_rf),
    .wdata_sel_o   (dec_wdata_sel),
    .is_two_byte_o (dec_two_byte),
    .sets_flag_o   (dec_sets_flag),
    .is_halt_o     (dec_halt),
    .is_jmp_o      (dec_jmp),
    .is_jz_o       (dec_jz)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    zflag_d   = zflag_q;
    rf_reset  = 1'b0;
    rf_we     = 1'b0;
    reg1      = '0;
    reg2      = '0;
    wreg      = '0;
    alu_op    = ALU_ADD;
    wdata_sel = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Gated so the strobe stays low while reset is still held.
        rf_reset = cu_reset_n;
        state_d  = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d = instr_data;
        pc_d = pc_q + AW'(1);
        if (dec_two_byte)  state_d = ST_FETCH_IMM;
        else if (dec_halt) state_d = ST_HALT;
        else               state_d = ST_EXEC;
      end
      ST_FETCH_IMM: state_d = ST_LOAD_IMM;
      ST_LOAD_IMM: begin
        imm_d   = instr_data;
        pc_d    = pc_q + AW'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        reg1      = RFW'(ir_q[3:2]);
        reg2      = RFW'(ir_q[1:0]);
        wreg      = RFW'(ir_q[3:2]);
        alu_op    = dec_alu_op;
        rf_we     = dec_writes_rf;
        wdata_sel = dec_wdata_sel;
        if (dec_sets_flag) zflag_d = alu_zero;
        if (dec_jmp || (dec_jz && zflag_q)) pc_d = AW'(imm_q);
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge cu_reset_n) begin
    if (!cu_reset_n) begin
      state_q <= ST_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      zflag_q <= zflag_d;
    end
  end

  assign instr_addr = pc_q;
  assign imm        = imm_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model builds the
// expected per-cycle output trace, compared against the DUT every cycle.
module tb_control_sequencer;
  import core_defs::*;

  logic       clk = 1'b0;
  logic       cu_reset_n;
  logic [7:0] instr_addr;
  logic [7:0] instr_data;
  logic       alu_zero;
  logic       rf_reset, rf_we, wdata_sel, halted;
  logic [1:0] reg1, reg2, wreg;
  logic [2:0] alu_op;
  logic [7:0] imm;
  state_e     dbg_state;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk        (clk),
    .cu_reset_n (cu_reset_n),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .alu_zero   (alu_zero),
    .rf_reset   (rf_reset),
    .rf_we      (rf_we),
    .reg1       (reg1),
    .reg2       (reg2),
    .wreg       (wreg),
    .alu_op     (alu_op),
    .wdata_sel  (wdata_sel),
    .imm        (imm),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // Synchronous instruction memory: data valid the cycle after the address.
  logic [7:0] mem [256];
  always @(posedge clk) instr_data <= mem[instr_addr];

  typedef struct packed {
    logic [7:0] addr;
    logic       rf_reset;
    logic       rf_we;
    logic [1:0] reg1;
    logic [1:0] reg2;
    logic [1:0] wreg;
    logic [2:0] alu_op;
    logic       wdata_sel;
    logic [7:0] imm;
    logic       halted;
  } obs_t;

  obs_t exp_q[$];
  obs_t dut_log [512];
  logic zero_at [512];
  int   total = 0;
  int   bad   = 0;

  function automatic obs_t sample();
    obs_t o;
    o.addr = instr_addr; o.rf_reset = rf_reset; o.rf_we = rf_we;
    o.reg1 = reg1; o.reg2 = reg2; o.wreg = wreg; o.alu_op = alu_op;
    o.wdata_sel = wdata_sel; o.imm = imm; o.halted = halted;
    return o;
  endfunction

  task automatic check_val(input string name, input int cyc,
                           input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Instruction-level model: walks the program, emitting one record per
  // cycle. Cycle 1 is the reset-release cycle (INIT).
  task automatic build_trace(input int n);
    logic [7:0] pc, ins, imm_m;
    logic [3:0] op;
    logic       z, hlt;
    int         idx;
    obs_t       r;
    exp_q.delete();
    r = '0; r.rf_reset = 1'b1;
    exp_q.push_back(r);
    pc = 8'h00; imm_m = 8'h00; z = 1'b0; hlt = 1'b0;
    while (exp_q.size() < n) begin
      if (hlt) begin
        r = '0; r.addr = pc; r.imm = imm_m; r.halted = 1'b1;
        exp_q.push_back(r);
      end else begin
        ins = mem[pc];
        op  = ins[7:4];
        r = '0; r.addr = pc; r.imm = imm_m;
        exp_q.push_back(r);
        exp_q.push_back(r);
        pc = pc + 8'd1;
        if (op == 4'hF) begin
          hlt = 1'b1;
        end else begin
          if (op >= 4'd7 && op <= 4'd9) begin
            r.addr = pc;
            exp_q.push_back(r);
            exp_q.push_back(r);
            imm_m = mem[pc];
            pc = pc + 8'd1;
          end
          r = '0; r.addr = pc; r.imm = imm_m;
          r.reg1 = ins[3:2]; r.reg2 = ins[1:0]; r.wreg = ins[3:2];
          if (op >= 4'd1 && op <= 4'd6) begin
            r.alu_op = 3'(op - 4'd1);
            r.rf_we  = 1'b1;
          end
          if (op == 4'd7) begin r.rf_we = 1'b1; r.wdata_sel = 1'b1; end
          idx = exp_q.size();
          exp_q.push_back(r);
          if (op >= 4'd1 && op <= 4'd5) z = zero_at[idx];
          if (op == 4'd8 || (op == 4'd9 && z)) pc = imm_m;
        end
      end
    end
  endtask

  task automatic do_reset();
    cu_reset_n = 1'b0;
    alu_zero   = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_prog(input string name, input int n);
    obs_t o;
    do_reset();
    build_trace(n);
    @(posedge clk);
    #1 cu_reset_n = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      o = sample();
      dut_log[k] = o;
      total++;
      if (o !== exp_q[k-1]) begin
        bad++;
        $display("FAIL %s trace cycle %0d: got %h expected %h", name, k, o, exp_q[k-1]);
      end
      alu_zero = zero_at[k-1];
    end
  endtask

  task automatic fill(input logic [7:0] b, input logic z);
    for (int i = 0; i < 256; i++) mem[i] = b;
    for (int i = 0; i < 512; i++) zero_at[i] = z;
  endtask

  function automatic int count_we(input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) if (dut_log[i].rf_we) c++;
    return c;
  endfunction

  initial begin
    cu_reset_n = 1'b0;
    alu_zero   = 1'b0;
    fill(8'hF0, 1'b0);

    // LDI r1,0x3C ; ADD r1,r2
    mem[0] = 8'h74; mem[1] = 8'h3C; mem[2] = 8'h16;
    run_prog("ldi_add", 15);
    check_val("init_rf_reset", 1, dut_log[1].rf_reset, 1);
    check_val("rf_reset_drop", 2, dut_log[2].rf_reset, 0);
    check_val("first_fetch_addr", 2, dut_log[2].addr, 0);
    check_val("ldi_we", 6, dut_log[6].rf_we, 1);
    check_val("ldi_wreg", 6, dut_log[6].wreg, 1);
    check_val("ldi_wsel", 6, dut_log[6].wdata_sel, 1);
    check_val("ldi_imm", 6, dut_log[6].imm, 8'h3C);
    check_val("add_we", 9, dut_log[9].rf_we, 1);
    check_val("add_reg2", 9, dut_log[9].reg2, 2);
    check_val("add_alu_op", 9, dut_log[9].alu_op, 0);
    check_val("add_wsel", 9, dut_log[9].wdata_sel, 0);
    check_val("we_pulse_count", 15, count_we(1, 15), 2);

    // SUB r3,r3 ; JZ 0x40 with alu_zero high, then low
    fill(8'hF0, 1'b1);
    mem[0] = 8'h2F; mem[1] = 8'h90; mem[2] = 8'h40;
    run_prog("jz_taken", 14);
    check_val("jz_taken_pc", 10, dut_log[10].addr, 8'h40);
    for (int i = 0; i < 512; i++) zero_at[i] = 1'b0;
    run_prog("jz_not_taken", 14);
    check_val("jz_fall_pc", 10, dut_log[10].addr, 8'h03);

    // SUB r0,r0 sets Z ; MOV r0,r0 must not clear it ; JZ 0x40
    fill(8'hF0, 1'b0);
    mem[0] = 8'h20; mem[1] = 8'h60; mem[2] = 8'h90; mem[3] = 8'h40;
    zero_at[3] = 1'b1;
    run_prog("mov_keeps_z", 16);
    check_val("mov_jz_pc", 13, dut_log[13].addr, 8'h40);

    // JMP 0xFF ; LDI at 0xFF with operand wrapping to 0x00
    fill(8'hF0, 1'b0);
    mem[0] = 8'h80; mem[1] = 8'hFF; mem[255] = 8'h74;
    run_prog("wrap", 16);
    check_val("wrap_fetch_ff", 7, dut_log[7].addr, 8'hFF);
    check_val("wrap_operand_addr", 9, dut_log[9].addr, 8'h00);
    check_val("wrap_ldi_imm", 11, dut_log[11].imm, 8'h80);
    check_val("wrap_ldi_we", 11, dut_log[11].rf_we, 1);
    check_val("wrap_next_pc", 12, dut_log[12].addr, 8'h01);

    // Undefined opcode 0xA5 as NOP, then HALT
    fill(8'hF0, 1'b0);
    mem[0] = 8'hA5;
    run_prog("nop_halt", 30);
    check_val("nop_no_we", 4, dut_log[4].rf_we, 0);
    check_val("nop_not_halted", 4, dut_log[4].halted, 0);
    check_val("halt_enter", 7, dut_log[7].halted, 1);
    check_val("halt_stays", 30, dut_log[30].halted, 1);
    check_val("halt_addr_frozen", 30, dut_log[30].addr, 8'h02);
    check_val("halt_no_we", 30, count_we(5, 30), 0);
    check_val("halt_state", 30, dbg_state, ST_HALT);

    // Reset asserted in the middle of an ADD's EXEC cycle
    fill(8'hF0, 1'b0);
    mem[0] = 8'h16;
    run_prog("abort", 4);
    check_val("abort_pre_we", 4, dut_log[4].rf_we, 1);
    cu_reset_n = 1'b0;
    #1;
    check_val("abort_we", 4, rf_we, 0);
    check_val("abort_pc", 4, instr_addr, 8'h00);
    check_val("abort_rf_reset", 4, rf_reset, 0);

    // Random programs and random alu_zero
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom_range(0, 255));
        if (mem[i][7:4] == 4'hF && $urandom_range(0, 9) != 0) mem[i] = mem[i] ^ 8'h10;
      end
      for (int i = 0; i < 512; i++) zero_at[i] = 1'($urandom_range(0, 1));
      run_prog("random", 150);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
